pdm_capture_ctrl: RTL and testbench
===================================

// Module: pdm_capture_ctrl
// PURPOSE
//  Sequences the PDM microphone front end: powers the mic clock, waits out mic wake-up, discards CIC
//  settling samples, then packs 16-bit PCM samples into fixed-length frames on an AXI-Stream-style
//  output with a small buffer. Sits between the PDM/CIC front end and the synth sample consumer.
//  Graceful stop (finish frame, drain) and sticky overrun reporting.
// PARAMETERS
//  WAKE_CYCLES     240000  clk cycles mic_en is held before samples are considered (2.4 ms @ 100 MHz)
//  SETTLE_SAMPLES  8       valid PCM samples discarded after wake-up (CIC settling)
//  LEN_W           12      width of frame_len / sample counter
//  FIFO_DEPTH      16      sample buffer entries, power of two, >= 2
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      pulse: begin capture (honoured only in IDLE)
//  stop         in   1      pulse: end capture after current frame
//  frame_len    in   LEN_W  samples per frame, latched on accepted start; 0 treated as 1
//  mic_en       out  1      enables PDM clock generator / mic power
//  pcm_data     in   16     PCM sample from CIC decimator
//  pcm_valid    in   1      single-cycle strobe, pcm_data valid
//  m_tdata      out  16     output sample
//  m_tvalid     out  1      output sample valid
//  m_tlast      out  1      last sample of frame
//  m_tready     in   1      consumer ready
//  busy         out  1      state != IDLE
//  overrun      out  1      sticky: sample dropped because buffer full; cleared by accepted start
// BEHAVIOUR
//  Reset (async): state IDLE; mic_en, m_tvalid, m_tlast, busy, overrun = 0; m_tdata = 0; buffer empty;
//   all counters 0. Reset mid-capture drops mic_en at once and discards buffered data.
//  States: IDLE -> WAKEUP -> SETTLE -> CAPTURE -> DRAIN -> IDLE.
//  IDLE: start && !stop -> WAKEUP, latch frame_len, clear overrun, wake_cnt=0. start&&stop same cycle: stay.
//  WAKEUP: mic_en=1; wake_cnt counts clk cycles; at WAKE_CYCLES-1 -> SETTLE. pcm_valid ignored.
//  SETTLE: mic_en=1; each pcm_valid increments discard count; the SETTLE_SAMPLES-th -> CAPTURE.
//   SETTLE_SAMPLES=0 skips straight to CAPTURE.
//  stop in WAKEUP or SETTLE -> IDLE next cycle, mic_en=0, nothing pushed.
//  CAPTURE: pcm_valid with buffer not full -> push {last, pcm_data}; last = (sample_cnt == len-1);
//   sample_cnt increments, wraps to 0 after last. Buffer full -> sample dropped, overrun set,
//   sample_cnt unchanged (frames always contiguous accepted samples, tlast never lost).
//   Push and pop same cycle on full buffer: pop frees slot, push accepted.
//  stop in CAPTURE sets stop_pending (stays set; repeated stop no effect). If sample_cnt==0 with no
//   push this cycle -> DRAIN next cycle; else -> DRAIN on the cycle the last-flagged sample is pushed.
//  DRAIN: mic_en=0; pcm_valid ignored; -> IDLE when buffer empty (same cycle final pop completes).
//  start outside IDLE ignored.
//  Output: first-word fall-through; sample pushed on cycle N appears on m_tdata/m_tvalid at N+1.
//   Pop when m_tvalid && m_tready. m_tdata/m_tlast stable while m_tvalid && !m_tready.
//   m_tlast valid only with m_tvalid, else 0.
//  Widths: counters LEN_W bits; wake_cnt $clog2(WAKE_CYCLES+1); settle count $clog2(SETTLE_SAMPLES+1).
// STRUCTURE
//  pdm_ctrl_pkg: typedef enum logic [2:0] cap_state_t {IDLE,WAKEUP,SETTLE,CAPTURE,DRAIN};
//   typedef struct packed {logic last; logic [15:0] data;} pcm_entry_t.
//  Sub-module pcm_sample_fifo (#DEPTH, pcm_entry_t): sync FWFT FIFO, async reset, full/empty,
//   simultaneous push/pop when full allowed. Controller FSM and counters stay in top.
// TESTING
//  1 WAKE_CYCLES=20, SETTLE=3, frame_len=4, tready=1, pcm_valid every 10 cycles -> mic_en at start+1,
//    first 3 valids after wake-up discarded, output 4,4,... with tlast on every 4th sample.
//  2 Mid-frame stop after 2nd sample of frame -> samples 3,4 still output, tlast on 4th, mic_en falls
//    same cycle as 4th push, busy falls after last pop.
//  3 tready=0, FIFO_DEPTH=4, 6 samples -> 4 buffered, 2 dropped, overrun=1; release tready -> 4 samples
//    in order, tlast position counted over accepted samples only; next start clears overrun.
//  4 stop during WAKEUP -> IDLE next cycle, mic_en=0, no m_tvalid; start+stop same cycle in IDLE -> stays.
//  5 reset asserted in CAPTURE with 3 buffered -> mic_en, m_tvalid, busy 0 without clock edge; buffer empty.
//  6 frame_len=0 -> every sample has tlast=1; frame_len changed mid-capture -> no effect until next start.

Source files
------------

// File: rtl/pdm_ctrl_pkg.sv
// Shared types for the PDM capture controller.
//   cap_state_t : controller state encoding
//   pcm_entry_t : one buffered sample plus its end-of-frame flag
package pdm_ctrl_pkg;

  localparam int PCM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAKEUP,
    SETTLE,
    CAPTURE,
    DRAIN
  } cap_state_t;

  typedef struct packed {
    logic             last;
    logic [PCM_W-1:0] data;
  } pcm_entry_t;

endpackage

// File: rtl/pcm_sample_fifo.sv
// Synchronous first-word-fall-through sample buffer.
//   clk, reset : clock, async active-high reset (empties the buffer)
//   push, din  : write request / entry (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever !empty
//   full, empty, count : occupancy
module pcm_sample_fifo
  import pdm_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  pcm_entry_t                 din,
  input  logic                       pop,
  output pcm_entry_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pcm_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on a full buffer frees the slot the concurrent push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty gates everything downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture sequencer: mic power-up wait, CIC settling discard,
// framing of PCM samples onto a stream output through a small FWFT buffer,
// graceful stop (finish frame, then drain) and sticky overrun.
//   clk, reset          : clock, async active-high reset
//   start, stop         : capture control pulses
//   frame_len           : samples per frame (0 acts as 1), latched on start
//   mic_en              : mic clock / power enable
//   pcm_data, pcm_valid : samples from the CIC decimator
//   m_tdata/tvalid/tlast/tready : sample stream out
//   busy, overrun       : status
module pdm_capture_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES    = 240000,
  parameter int SETTLE_SAMPLES = 8,
  parameter int LEN_W          = 12,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  output logic             mic_en,
  input  logic [15:0]      pcm_data,
  input  logic             pcm_valid,
  output logic [15:0]      m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             overrun
);

  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WW-1:0] WAKE_LAST   = WW'(WAKE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

  cap_state_t       state, state_nxt;
  logic [WW-1:0]    wake_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [LEN_W-1:0] len_m1, sample_cnt;
  logic             stop_pend;

  logic             push, pop, drop, full, empty, is_last, stop_req, capturing;
  logic [CW-1:0]    fifo_cnt;
  pcm_entry_t       din, dout;

  assign capturing = (state == CAPTURE);
  assign is_last   = (sample_cnt == len_m1);
  assign pop       = !empty && m_tready;
  assign push      = capturing && pcm_valid && (!full || pop);
  // A dropped sample leaves sample_cnt alone so frames stay contiguous.
  assign drop      = capturing && pcm_valid && !push;
  assign stop_req  = stop_pend || stop;
  assign din       = '{last: is_last, data: pcm_data};

  pcm_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : dout.data;
  assign m_tlast  = !empty && dout.last;
  assign busy     = (state != IDLE);
  assign mic_en   = (state == WAKEUP) || (state == SETTLE) || (state == CAPTURE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = WAKEUP;
      WAKEUP:  if (stop) state_nxt = IDLE;
               else if (wake_cnt == WAKE_LAST)
                 state_nxt = (SETTLE_SAMPLES == 0) ? CAPTURE : SETTLE;
      SETTLE:  if (stop) state_nxt = IDLE;
               else if (pcm_valid && settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
      // Stop waits for a frame boundary: either nothing of the current frame
      // has been accepted yet, or its last sample is going in right now.
      CAPTURE: if (stop_req && ((push && is_last) || (sample_cnt == '0 && !push)))
                 state_nxt = DRAIN;
      DRAIN:   if (empty || (pop && fifo_cnt == CW'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wake_cnt   <= '0;
      settle_cnt <= '0;
      len_m1     <= '0;
      sample_cnt <= '0;
      stop_pend  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !stop) begin
          len_m1     <= (frame_len == '0) ? '0 : frame_len - LEN_W'(1);
          overrun    <= 1'b0;
          wake_cnt   <= '0;
          settle_cnt <= '0;
          sample_cnt <= '0;
          stop_pend  <= 1'b0;
        end
        WAKEUP: wake_cnt <= wake_cnt + WW'(1);
        SETTLE: if (pcm_valid) settle_cnt <= settle_cnt + SW'(1);
        CAPTURE: begin
          if (push)  sample_cnt <= is_last ? '0 : sample_cnt + LEN_W'(1);
          if (drop)  overrun    <= 1'b1;
          if (stop)  stop_pend  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
module tb_pdm_capture_ctrl;

  localparam int WAKE   = 20;
  localparam int SETTLE = 3;
  localparam int LEN_W  = 12;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             reset, start, stop, pcm_valid, m_tready;
  logic [LEN_W-1:0] frame_len;
  logic [15:0]      pcm_data, m_tdata;
  logic             mic_en, m_tvalid, m_tlast, busy, overrun;

  pdm_capture_ctrl #(
    .WAKE_CYCLES(WAKE), .SETTLE_SAMPLES(SETTLE), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .frame_len(frame_len),
    .mic_en(mic_en), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase + queue view) ----------------
  localparam int P_IDLE = 0, P_WAKE = 1, P_SETTLE = 2, P_CAP = 3, P_DRAIN = 4;
  int          md_phase, md_wake_left, md_settle_left, md_len, md_pos;
  bit          md_stop_req, md_ovr;
  logic [16:0] md_q[$];

  function automatic void md_reset();
    md_phase = P_IDLE; md_wake_left = 0; md_settle_left = 0; md_len = 1; md_pos = 0;
    md_stop_req = 0; md_ovr = 0; md_q.delete();
  endfunction

  function automatic logic [20:0] md_out();
    logic mic, vld;
    mic = (md_phase == P_WAKE) || (md_phase == P_SETTLE) || (md_phase == P_CAP);
    vld = md_q.size() > 0;
    return {mic, md_phase != P_IDLE, vld, vld ? md_q[0][16] : 1'b0, md_ovr,
            vld ? md_q[0][15:0] : 16'h0};
  endfunction

  function automatic void md_step();
    bit pop, push, last;
    int pos0;
    pop = (md_q.size() > 0) && m_tready;
    push = 0; last = 0;
    case (md_phase)
      P_IDLE: if (start && !stop) begin
        md_phase = P_WAKE; md_wake_left = WAKE; md_ovr = 0; md_pos = 0; md_stop_req = 0;
        md_len = (frame_len == 0) ? 1 : int'(frame_len);
      end
      P_WAKE: if (stop) md_phase = P_IDLE;
        else begin
          md_wake_left--;
          if (md_wake_left == 0) begin
            md_phase = P_SETTLE; md_settle_left = SETTLE;
          end
        end
      P_SETTLE: if (stop) md_phase = P_IDLE;
        else if (pcm_valid) begin
          md_settle_left--;
          if (md_settle_left == 0) md_phase = P_CAP;
        end
      P_CAP: begin
        pos0 = md_pos;
        push = pcm_valid && (md_q.size() < DEPTH || pop);
        if (pcm_valid && !push) md_ovr = 1;
        if (push) begin
          last = (md_pos == md_len - 1);
          md_pos = last ? 0 : md_pos + 1;
        end
        if (stop) md_stop_req = 1;
        if (md_stop_req && ((push && last) || (pos0 == 0 && !push))) md_phase = P_DRAIN;
      end
      P_DRAIN: if (md_q.size() - (pop ? 1 : 0) == 0) md_phase = P_IDLE;
      default: ;
    endcase
    if (pop) void'(md_q.pop_front());
    if (push) md_q.push_back({last, pcm_data});
  endfunction

  // Per-cycle cross-check and accepted-output capture, away from the clock edge.
  logic [16:0] got[$];
  always @(negedge clk) begin
    if (reset) md_reset();
    chk("model_cycle", {11'h0, mic_en, busy, m_tvalid, m_tlast, overrun, m_tdata}, {11'h0, md_out()});
    if (!reset) begin
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      md_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(int len);
    frame_len = LEN_W'(len); start = 1; cyc(1); start = 0;
  endtask

  task automatic do_stop();
    stop = 1; cyc(1); stop = 0;
  endtask

  task automatic send(logic [15:0] d);
    pcm_data = d; pcm_valid = 1; cyc(1); pcm_valid = 0; cyc(2);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 300) begin cyc(1); n++; end
    chk(name, {31'h0, busy}, 0);
  endtask

  task automatic wake_and_settle(int len);
    do_start(len);
    cyc(WAKE + 5);
    for (int i = 0; i < SETTLE; i++) send(16'hdead);
  endtask

  typedef struct {
    int          len;
    int          n;
    int          stop_at;
    int          exp_cnt;
    logic [15:0] exp_last;
  } vec_t;
  vec_t vt[7];

  logic [16:0] exp3[6];

  initial begin
    vt[0] = '{4, 8, 8, 8, 16'h0088};
    vt[1] = '{0, 3, 3, 3, 16'h0007};
    vt[2] = '{1, 2, 2, 2, 16'h0003};
    vt[3] = '{3, 6, 6, 6, 16'h0024};
    vt[4] = '{4, 8, 2, 4, 16'h0008};
    vt[5] = '{5, 5, 0, 0, 16'h0000};
    vt[6] = '{2, 5, 3, 4, 16'h000a};
    exp3 = '{{1'b0, 16'h3000}, {1'b0, 16'h3001}, {1'b1, 16'h3002},
             {1'b0, 16'h3003}, {1'b0, 16'h3006}, {1'b1, 16'h3007}};

    reset = 0; start = 0; stop = 0; pcm_valid = 0; pcm_data = 0; m_tready = 1; frame_len = 0;
    #2 reset = 1;
    #1;
    chk("rst_outputs", {26'h0, mic_en, m_tvalid, m_tlast, busy, overrun}, 0);
    chk("rst_tdata", {16'h0, m_tdata}, 0);
    cyc(2);
    reset = 0;
    cyc(1);

    // mic enable timing and stop during wake-up
    chk("idle_mic", {31'h0, mic_en}, 0);
    do_start(4);
    chk("start_mic", {30'h0, mic_en, busy}, 2'b11);
    cyc(5);
    do_stop();
    chk("wake_stop", {29'h0, mic_en, busy, m_tvalid}, 0);
    frame_len = 4; start = 1; stop = 1; cyc(1); start = 0; stop = 0;
    chk("start_stop_idle", {31'h0, busy}, 0);

    // framing table: start, retarget frame_len mid-capture, feed, stop, drain
    for (int k = 0; k < 7; k++) begin
      logic [15:0] base, lm;
      base = 16'((k + 1) * 256);
      got.delete();
      wake_and_settle(vt[k].len);
      frame_len = (vt[k].len == 3) ? 12'd1 : 12'd3;
      for (int i = 0; i < vt[k].n; i++) begin
        if (i == vt[k].stop_at) do_stop();
        send(base + 16'(i));
      end
      if (vt[k].stop_at == vt[k].n) do_stop();
      wait_idle("tbl_idle");
      chk("tbl_cnt", got.size(), vt[k].exp_cnt);
      lm = '0;
      for (int i = 0; i < got.size() && i < 16; i++) begin
        chk("tbl_data", {16'h0, got[i][15:0]}, {16'h0, base + 16'(i)});
        lm[i] = got[i][16];
      end
      chk("tbl_last", {16'h0, lm}, {16'h0, vt[k].exp_last});
    end

    // overrun: back-pressure, drops, in-order release, sticky until start
    got.delete();
    wake_and_settle(3);
    m_tready = 0;
    for (int i = 0; i < 6; i++) send(16'h3000 + 16'(i));
    chk("ovr_set", {31'h0, overrun}, 1);
    chk("ovr_head", {15'h0, m_tvalid, m_tdata}, {15'h0, 1'b1, 16'h3000});
    m_tready = 1;
    cyc(8);
    do_stop();
    send(16'h3006);
    send(16'h3007);
    wait_idle("ovr_idle");
    chk("ovr_cnt", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("ovr_seq", {15'h0, got[i]}, {15'h0, exp3[i]});
    chk("ovr_sticky", {31'h0, overrun}, 1);
    do_start(2);
    chk("ovr_clear", {31'h0, overrun}, 0);
    do_stop();

    // async reset mid-capture with samples buffered
    wake_and_settle(8);
    m_tready = 0;
    for (int i = 0; i < 3; i++) send(16'h5000 + 16'(i));
    chk("pre_rst_vld", {30'h0, m_tvalid, mic_en}, 2'b11);
    #2 reset = 1;
    #1;
    chk("async_rst", {29'h0, mic_en, m_tvalid, busy}, 0);
    chk("async_rst_data", {16'h0, m_tdata}, 0);
    #3 reset = 0;
    m_tready = 1;
    cyc(2);
    chk("post_rst_empty", {30'h0, m_tvalid, busy}, 0);

    // randomized traffic, checked cycle by cycle against the model
    for (int r = 0; r < 6; r++) begin
      int n;
      do_start($urandom_range(0, 6));
      repeat (220) begin
        pcm_valid = ($urandom_range(0, 2) == 0);
        pcm_data  = 16'($urandom);
        m_tready  = ($urandom_range(0, 3) != 0);
        stop      = ($urandom_range(0, 79) == 0);
        start     = ($urandom_range(0, 49) == 0);
        frame_len = LEN_W'($urandom_range(0, 6));
        cyc(1);
      end
      pcm_valid = 0; start = 0; stop = 0; m_tready = 1;
      do_stop();
      n = 0;
      while (busy && n < 400) begin
        pcm_valid = n[0]; pcm_data = 16'($urandom); cyc(1); n++;
      end
      pcm_valid = 0;
      chk("rand_idle", {31'h0, busy}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
